imem_word_arbiter: RTL

IMEM_WORD_ARBITER -- requirements
Module: imem_word_arbiter

---
 rtl/imem_word_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/imem_word_arbiter.sv
// Arbitrates fetch and loader word accesses onto a byte-wide memory, four big-endian beats per word.
// Define FETCH_PRIORITY_EN to give fetch fixed priority instead of round-robin arbitration.
module imem_word_arbiter #(
  parameter int ADR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_req,
  input  logic [31:0]      f_adr,
  output logic [31:0]      f_data,
  output logic             f_done,
  input  logic             l_req,
  input  logic             l_we,
  input  logic [31:0]      l_adr,
  input  logic [31:0]      l_wdata,
  output logic [31:0]      l_rdata,
  output logic             l_done,
  output logic [ADR_W-1:0] m_adr,
  output logic             m_we,
  output logic [7:0]       m_wdata,
  input  logic [7:0]       m_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t           state_q, state_d;
  logic [ADR_W-3:0] word_q;
  logic [1:0]       beat_q;
  logic [4:0]       lane;
  logic             grant_load_q, grant_load_d;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic             start;
  logic             unused_adr_bits;

  // Only the in-memory word index of each address is meaningful.
  assign unused_adr_bits = ^{f_adr[31:ADR_W], f_adr[1:0], l_adr[31:ADR_W], l_adr[1:0]};
  assign start           = f_req | l_req;

`ifdef FETCH_PRIORITY_EN
  assign grant_load_d = ~f_req;
`else
  logic last_load_q;

  // Loader wins a tie only when fetch was the last port granted.
  assign grant_load_d = l_req & (~f_req | ~last_load_q);

  always_ff @(posedge clk) begin
    if (!rst_n)                       last_load_q <= 1'b1;
    else if (state_q == IDLE && start) last_load_q <= grant_load_d;
  end
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = XFER;
      XFER:    if (beat_q == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat b carries word bits [31-8b -: 8]; for a 2-bit b that offset is {~b, 3'b000}.
  assign lane = {~beat_q, 3'b000};

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= 2'd0;
      word_q       <= '0;
      grant_load_q <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      f_data       <= 32'h0;
      l_rdata      <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        grant_load_q <= grant_load_d;
        word_q       <= grant_load_d ? l_adr[ADR_W-1:2] : f_adr[ADR_W-1:2];
        we_q         <= grant_load_d & l_we;
        wdata_q      <= l_wdata;
        beat_q       <= 2'd0;
      end
      if (state_q == XFER) begin
        beat_q <= beat_q + 2'd1;
        if (!we_q) begin
          if (grant_load_q) l_rdata[lane +: 8] <= m_rdata;
          else              f_data[lane +: 8]  <= m_rdata;
        end
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign f_done  = (state_q == DONE) & ~grant_load_q;
  assign l_done  = (state_q == DONE) &  grant_load_q;
  assign m_adr   = (state_q == XFER) ? {word_q, beat_q} : '0;
  // NOTE: the write strobe is gated by rst_n so a reset cycle never commits the beat in flight.
  assign m_we    = rst_n & (state_q == XFER) & we_q;
  assign m_wdata = (state_q == XFER && we_q) ? wdata_q[lane +: 8] : 8'h00;

endmodule
